// File: rtl/amo_unit.sv
// RV32A read-modify-write engine: LR.W / SC.W / AMO*.W with a single snooped reservation.
// Define AMO_MINMAX_EN to build AMOMIN/AMOMAX/AMOMINU/AMOMAXU; otherwise those encodings are illegal.
module amo_unit #(
    parameter int RD_LAT = 1
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iSTART,
    input  logic [4:0]  iFUNCT5,
    input  logic [31:0] iRS1,
    input  logic [31:0] iRS2,
    output logic        oBUSY,
    output logic        oDONE,
    output logic [31:0] oRESULT,
    output logic        oMISALIGN,
    output logic        oILLEGAL,
    input  logic        iST_WR,
    input  logic [7:0]  iST_ADDR,
    output logic        oRAM_CE,
    output logic        oRAM_RD,
    output logic        oRAM_WR,
    output logic [7:0]  oRAM_ADDR,
    output logic [31:0] oRAM_DATA_WR,
    input  logic [31:0] iRAM_DATA_RD
);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} stateT;
    typedef enum logic [3:0] {
        OP_ADD, OP_SWAP, OP_LR, OP_SC, OP_XOR, OP_AND, OP_OR,
        OP_MIN, OP_MAX, OP_MINU, OP_MAXU, OP_BAD
    } opT;

    localparam int CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    stateT            state;
    opT               opReg, startOp;
    logic [7:0]       addrReg;
    logic [31:0]      rs2Reg, oldReg, amoNew;
    logic [CntW-1:0]  waitCnt;
    logic             resValid;
    logic [7:0]       resAddr;
    logic             scPass, snoopHitRes;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        startOp = OP_BAD;
        case (iFUNCT5)
            5'b00000: startOp = OP_ADD;
            5'b00001: startOp = OP_SWAP;
            5'b00010: startOp = OP_LR;
            5'b00011: startOp = OP_SC;
            5'b00100: startOp = OP_XOR;
            5'b01100: startOp = OP_AND;
            5'b01000: startOp = OP_OR;
`ifdef AMO_MINMAX_EN
            5'b10000: startOp = OP_MIN;
            5'b10100: startOp = OP_MAX;
            5'b11000: startOp = OP_MINU;
            5'b11100: startOp = OP_MAXU;
`endif
            default:  startOp = OP_BAD;
        endcase
    end

    // New memory value from the word arriving in the last WAIT cycle; ties keep the old word.
    always_comb begin
        amoNew = rs2Reg;
        case (opReg)
            OP_ADD:  amoNew = iRAM_DATA_RD + rs2Reg;
            OP_XOR:  amoNew = iRAM_DATA_RD ^ rs2Reg;
            OP_AND:  amoNew = iRAM_DATA_RD & rs2Reg;
            OP_OR:   amoNew = iRAM_DATA_RD | rs2Reg;
`ifdef AMO_MINMAX_EN
            OP_MIN:  amoNew = ($signed(rs2Reg) < $signed(iRAM_DATA_RD)) ? rs2Reg : iRAM_DATA_RD;
            OP_MAX:  amoNew = ($signed(rs2Reg) > $signed(iRAM_DATA_RD)) ? rs2Reg : iRAM_DATA_RD;
            OP_MINU: amoNew = (rs2Reg < iRAM_DATA_RD) ? rs2Reg : iRAM_DATA_RD;
            OP_MAXU: amoNew = (rs2Reg > iRAM_DATA_RD) ? rs2Reg : iRAM_DATA_RD;
`endif
            default: amoNew = rs2Reg;
        endcase
    end

    assign snoopHitRes = iST_WR && (iST_ADDR == resAddr);
    assign scPass      = resValid && !snoopHitRes && (resAddr == iRS1[9:2]);

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state        <= IDLE;
            opReg        <= OP_BAD;
            addrReg      <= '0;
            rs2Reg       <= '0;
            oldReg       <= '0;
            waitCnt      <= '0;
            resValid     <= 1'b0;
            resAddr      <= '0;
            oBUSY        <= 1'b0;
            oDONE        <= 1'b0;
            oRESULT      <= '0;
            oMISALIGN    <= 1'b0;
            oILLEGAL     <= 1'b0;
            oRAM_CE      <= 1'b0;
            oRAM_RD      <= 1'b0;
            oRAM_WR      <= 1'b0;
            oRAM_ADDR    <= '0;
            oRAM_DATA_WR <= '0;
        end else begin
            if (snoopHitRes) resValid <= 1'b0;
            case (state)
                IDLE: if (iSTART) begin
                    opReg   <= startOp;
                    addrReg <= iRS1[9:2];
                    rs2Reg  <= iRS2;
                    oBUSY   <= 1'b1;
                    if (iRS1[1:0] != 2'b00) begin
                        state     <= DONE;
                        oDONE     <= 1'b1;
                        oMISALIGN <= 1'b1;
                    end else if (startOp == OP_BAD) begin
                        state    <= DONE;
                        oDONE    <= 1'b1;
                        oILLEGAL <= 1'b1;
                    end else if (startOp == OP_SC) begin
                        resValid <= 1'b0;
                        if (scPass) begin
                            state        <= WR;
                            oRAM_CE      <= 1'b1;
                            oRAM_WR      <= 1'b1;
                            oRAM_ADDR    <= iRS1[9:2];
                            oRAM_DATA_WR <= iRS2;
                        end else begin
                            state   <= DONE;
                            oDONE   <= 1'b1;
                            oRESULT <= 32'd1;
                        end
                    end else begin
                        state     <= RD;
                        oRAM_CE   <= 1'b1;
                        oRAM_RD   <= 1'b1;
                        oRAM_ADDR <= iRS1[9:2];
                    end
                end
                RD: begin
                    state   <= WAIT;
                    oRAM_RD <= 1'b0;
                    waitCnt <= CntW'(RD_LAT - 1);
                end
                WAIT: if (waitCnt == '0) begin
                    oldReg <= iRAM_DATA_RD;
                    if (opReg == OP_LR) begin
                        state     <= DONE;
                        oRAM_CE   <= 1'b0;
                        oRAM_ADDR <= '0;
                        oDONE     <= 1'b1;
                        oRESULT   <= iRAM_DATA_RD;
                    end else begin
                        state        <= WR;
                        oRAM_WR      <= 1'b1;
                        oRAM_DATA_WR <= amoNew;
                    end
                end else begin
                    waitCnt <= waitCnt - 1'b1;
                end
                WR: begin
                    state        <= DONE;
                    oRAM_CE      <= 1'b0;
                    oRAM_WR      <= 1'b0;
                    oRAM_ADDR    <= '0;
                    oRAM_DATA_WR <= '0;
                    oDONE        <= 1'b1;
                    oRESULT      <= (opReg == OP_SC) ? 32'd0 : oldReg;
                end
                DONE: begin
                    state     <= IDLE;
                    oBUSY     <= 1'b0;
                    oDONE     <= 1'b0;
                    oRESULT   <= '0;
                    oMISALIGN <= 1'b0;
                    oILLEGAL  <= 1'b0;
                    // The reservation is armed on leaving DONE so a snoop in the DONE cycle still kills it.
                    if (opReg == OP_LR && !oMISALIGN) begin
                        resAddr  <= addrReg;
                        resValid <= !(iST_WR && (iST_ADDR == addrReg));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_amo_unit.sv
// Directed bench for amo_unit with a one-cycle-latency RAM model.
// Covers AMO/LR/SC timing, snoop kill, misaligned/illegal paths, min/max build option and async reset.
module tb_amo_unit;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic [4:0]  funct5;
    logic [31:0] rs1Drv, rs2Drv;
    logic        busy, done, misalign, illegal;
    logic [31:0] result;
    logic        stWr;
    logic [7:0]  stAddr;
    logic        ramCe, ramRd, ramWr;
    logic [7:0]  ramAddr;
    logic [31:0] ramDataWr, ramDataRd;

    logic [31:0] mem [0:255];
    int          ceCount = 0;
    int          wrCount = 0;

    int          nCompared = 0;
    int          nMismatch = 0;

    int          lat, ceBase, wrBase;
    logic [31:0] res;
    logic        mis, ill;

    amo_unit #(.RD_LAT(1)) dut (
        .iCLK(clk), .iRST_N(rstN), .iSTART(start), .iFUNCT5(funct5),
        .iRS1(rs1Drv), .iRS2(rs2Drv), .oBUSY(busy), .oDONE(done),
        .oRESULT(result), .oMISALIGN(misalign), .oILLEGAL(illegal),
        .iST_WR(stWr), .iST_ADDR(stAddr), .oRAM_CE(ramCe), .oRAM_RD(ramRd),
        .oRAM_WR(ramWr), .oRAM_ADDR(ramAddr), .oRAM_DATA_WR(ramDataWr),
        .iRAM_DATA_RD(ramDataRd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ramCe && ramRd) ramDataRd <= mem[ramAddr];
        if (ramCe && ramWr) mem[ramAddr] <= ramDataWr;
        if (ramCe) ceCount <= ceCount + 1;
        if (ramCe && ramWr) wrCount <= wrCount + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatch++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge with the unit idle; returns one cycle after DONE.
    task automatic doOp(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic snoopAtDone, input logic [7:0] snoopAddr);
        funct5 = f;
        rs1Drv = a;
        rs2Drv = b;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        mis = misalign;
        ill = illegal;
        if (snoopAtDone) begin
            stWr   = 1'b1;
            stAddr = snoopAddr;
        end
        @(posedge clk); #1;
        stWr = 1'b0;
    endtask

    task automatic runOp(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        doOp(f, a, b, 1'b0, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'h7FFF_FFFF;
        mem[8'h05] = 32'h0000_00A5;
        mem[8'h06] = 32'h0000_0066;
        mem[8'h08] = 32'h1234_5678;
        mem[8'h20] = 32'hFFFF_FFFF;
        mem[8'h30] = 32'hF0F0_F0F0;
        mem[8'h40] = 32'hCAFE_BABE;
        ramDataRd = 32'h0;
        rstN   = 1'b0;
        start  = 1'b0;
        funct5 = 5'h0;
        rs1Drv = 32'h0;
        rs2Drv = 32'h0;
        stWr   = 1'b0;
        stAddr = 8'h0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", 32'({busy, done, misalign, illegal, ramCe, ramRd, ramWr}), 32'h0);
        check("reset_addr", 32'(ramAddr), 32'h0);
        check("reset_result", result, 32'h0);
        check("reset_wdata", ramDataWr, 32'h0);
        rstN = 1'b1;
        @(posedge clk); #1;

        // AMOADD wraps into the sign bit
        wrBase = wrCount;
        runOp(5'b00000, 32'h40, 32'h1);
        check("add_lat", 32'(lat), 32'd4);
        check("add_result", res, 32'h7FFF_FFFF);
        check("add_mem", mem[8'h10], 32'h8000_0000);
        check("add_wr_cycles", 32'(wrCount - wrBase), 32'd1);

        // LR then SC pass, then a second SC fails
        runOp(5'b00010, 32'h14, 32'h0);
        check("lr_lat", 32'(lat), 32'd3);
        check("lr_result", res, 32'hA5);
        runOp(5'b00011, 32'h14, 32'h55);
        check("sc_pass_lat", 32'(lat), 32'd2);
        check("sc_pass_result", res, 32'h0);
        check("sc_pass_mem", mem[8'h05], 32'h55);
        wrBase = wrCount;
        runOp(5'b00011, 32'h14, 32'h77);
        check("sc2_lat", 32'(lat), 32'd1);
        check("sc2_result", res, 32'h1);
        check("sc2_no_write", 32'(wrCount - wrBase), 32'd0);
        check("sc2_mem", mem[8'h05], 32'h55);

        // Snoop on the reserved word kills the reservation
        runOp(5'b00010, 32'h20, 32'h0);
        check("lr_snoop_result", res, 32'h1234_5678);
        stWr = 1'b1;
        stAddr = 8'h08;
        @(posedge clk); #1;
        stWr = 1'b0;
        runOp(5'b00011, 32'h20, 32'hDEAD);
        check("snoop_kill_result", res, 32'h1);
        check("snoop_kill_mem", mem[8'h08], 32'h1234_5678);

        // Snoop to another word leaves the reservation intact
        runOp(5'b00010, 32'h20, 32'h0);
        stWr = 1'b1;
        stAddr = 8'h09;
        @(posedge clk); #1;
        stWr = 1'b0;
        runOp(5'b00011, 32'h20, 32'hBEEF);
        check("snoop_miss_result", res, 32'h0);
        check("snoop_miss_mem", mem[8'h08], 32'hBEEF);

        // Snoop in the LR DONE cycle wins over setting the reservation
        doOp(5'b00010, 32'h20, 32'h0, 1'b1, 8'h08);
        check("lr_done_snoop_result", res, 32'hBEEF);
        runOp(5'b00011, 32'h20, 32'h1111);
        check("done_snoop_sc_result", res, 32'h1);
        check("done_snoop_mem", mem[8'h08], 32'hBEEF);

        // SC to a different word fails and still clears the reservation
        runOp(5'b00010, 32'h14, 32'h0);
        runOp(5'b00011, 32'h18, 32'h2222);
        check("sc_other_result", res, 32'h1);
        check("sc_other_mem", mem[8'h06], 32'h66);
        runOp(5'b00011, 32'h14, 32'h3333);
        check("sc_after_clear_result", res, 32'h1);
        check("sc_after_clear_mem", mem[8'h05], 32'h55);

        // Misaligned AMOSWAP: immediate DONE, no RAM access
        ceBase = ceCount;
        runOp(5'b00001, 32'h42, 32'h9);
        check("mis_lat", 32'(lat), 32'd1);
        check("mis_flags", 32'({mis, ill}), 32'b10);
        check("mis_result", res, 32'h0);
        check("mis_no_ce", 32'(ceCount - ceBase), 32'd0);

        // Misalignment takes precedence over an illegal funct5
        runOp(5'b11111, 32'h41, 32'h0);
        check("mis_ill_flags", 32'({mis, ill}), 32'b10);

        // Illegal funct5, aligned address
        ceBase = ceCount;
        runOp(5'b00101, 32'h44, 32'h0);
        check("ill_lat", 32'(lat), 32'd1);
        check("ill_flags", 32'({mis, ill}), 32'b01);
        check("ill_result", res, 32'h0);
        check("ill_no_ce", 32'(ceCount - ceBase), 32'd0);

        // Bitwise AMOs chained on one word
        runOp(5'b00100, 32'hC0, 32'hFF00_FF00);
        check("xor_result", res, 32'hF0F0_F0F0);
        check("xor_mem", mem[8'h30], 32'h0FF0_0FF0);
        runOp(5'b01100, 32'hC0, 32'h0000_FFFF);
        check("and_result", res, 32'h0FF0_0FF0);
        check("and_mem", mem[8'h30], 32'h0000_0FF0);
        runOp(5'b01000, 32'hC0, 32'h1100_0000);
        check("or_result", res, 32'h0000_0FF0);
        check("or_mem", mem[8'h30], 32'h1100_0FF0);

`ifdef AMO_MINMAX_EN
        runOp(5'b10000, 32'h80, 32'h1);
        check("min_lat", 32'(lat), 32'd4);
        check("min_result", res, 32'hFFFF_FFFF);
        check("min_mem", mem[8'h20], 32'hFFFF_FFFF);
        runOp(5'b11000, 32'h80, 32'h1);
        check("minu_result", res, 32'hFFFF_FFFF);
        check("minu_mem", mem[8'h20], 32'h1);
`else
        ceBase = ceCount;
        runOp(5'b10000, 32'h80, 32'h1);
        check("min_off_lat", 32'(lat), 32'd1);
        check("min_off_flags", 32'({mis, ill}), 32'b01);
        check("min_off_result", res, 32'h0);
        check("min_off_no_ce", 32'(ceCount - ceBase), 32'd0);
        check("min_off_mem", mem[8'h20], 32'hFFFF_FFFF);
`endif

        // Asynchronous reset while the AMOSWAP write strobe is up
        wrBase = wrCount;
        funct5 = 5'b00001;
        rs1Drv = 32'h100;
        rs2Drv = 32'h1;
        start  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (ramWr) break;
        end
        check("rst_reached_wr", 32'({ramWr, busy}), 32'b11);
        #2;
        rstN = 1'b0;
        #1;
        check("rst_async_ctrl", 32'({busy, done, misalign, illegal, ramCe, ramRd, ramWr}), 32'h0);
        check("rst_async_addr", 32'(ramAddr), 32'h0);
        check("rst_async_wdata", ramDataWr, 32'h0);
        @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;
        runOp(5'b00010, 32'h100, 32'h0);
        check("rst_lr_result", res, 32'hCAFE_BABE);
        check("rst_no_write", 32'(wrCount - wrBase), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
